bus0_slv_decoder: RTL
=====================

BUS0_SLV_DECODER -- requirements
Module: bus0_slv_decoder

Interface
REQ-001 SHALL have parameter abits, default 48, giving the system bus address width.
REQ-002 SHALL have port i_clk, in, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rst, in, 1: reset, synchronous and active-high.
REQ-004 SHALL have ports i_req_valid in 1, o_req_ready out 1, i_req_addr in abits, i_req_write in 1, i_req_len in 8: master AR/AW request.
REQ-005 SHALL have ports o_sel_valid out 1, i_sel_ready in 1, o_sel_idx out 3, o_sel_addr out abits, o_sel_write out 1, o_sel_len out 8: routed request to slave index 0..6 of the bus0 slave vector.
REQ-006 SHALL have ports i_w_valid in 1, i_w_last in 1, o_w_ready out 1: write-data absorb handshake for unmapped writes.
REQ-007 SHALL have ports o_b_valid out 1, o_b_resp out 2, i_b_ready in 1: write response for unmapped writes.
REQ-008 SHALL have ports o_r_valid out 1, o_r_resp out 2, o_r_last out 1, o_r_data out 64, i_r_ready in 1: read data for unmapped reads.

Function
REQ-009 SHALL implement states IDLE, ROUTE, ERR_W, ERR_B, ERR_R.
REQ-010 SHALL assert o_req_ready only in IDLE; a request is accepted on i_req_valid & o_req_ready.
REQ-011 SHALL latch addr, write and len on acceptance and decode them in the same cycle into a registered result; one request outstanding at a time.
REQ-012 SHALL treat slave k as hit when base_k <= addr < end_k, using the bus0 address map (bootrom 0x10000-0x20000, clint 0x2000000-0x2010000, sram 0x8000000-0x8200000, plic 0xC000000-0x10000000, pbridge 0x10000000-0x10100000, ddr 0x80000000-0xC0000000, new 0x100000000-0x110000000), compared over abits bits; end is exclusive.
REQ-013 SHALL select the lowest hit index when several entries match.
REQ-014 On hit, SHALL go IDLE->ROUTE and assert o_sel_valid with o_sel_idx/addr/write/len from the cycle after acceptance (latency 1).
REQ-015 SHALL hold o_sel_* stable while o_sel_valid & !i_sel_ready; on o_sel_valid & i_sel_ready SHALL return to IDLE, deassert o_sel_valid next cycle.
REQ-016 On miss with write=1, SHALL go to ERR_W; o_sel_valid stays 0.
REQ-017 In ERR_W, SHALL assert o_w_ready and discard beats; on i_w_valid & i_w_last SHALL go to ERR_B regardless of beat count vs len.
REQ-018 In ERR_B, SHALL assert o_b_valid with o_b_resp=2'b11 (DECERR); on i_b_ready SHALL return to IDLE.
REQ-019 On miss with write=0, SHALL go to ERR_R with an 8-bit beat counter loaded with len.
REQ-020 In ERR_R, SHALL assert o_r_valid, o_r_resp=2'b11, o_r_data=0, o_r_last=(counter==0); each i_r_ready decrements; i_r_ready with o_r_last returns to IDLE; exactly len+1 beats (len=255 -> 256 beats, no wrap).
REQ-021 SHALL keep o_r_valid, o_r_resp, o_r_last, o_b_valid, o_b_resp, o_w_ready at 0 outside their own states.
REQ-022 SHALL hold state and response outputs unchanged while the consumer backpressures (ready low).

Reset
REQ-023 With i_rst=1 at a rising edge, SHALL enter IDLE next cycle from any state, aborting any routed or error transaction.
REQ-024 Reset values: o_req_ready=0 during reset, 1 in the first IDLE cycle after; o_sel_valid=0, o_sel_idx=0, o_sel_addr=0, o_sel_write=0, o_sel_len=0, o_w_ready=0, o_b_valid=0, o_b_resp=0, o_r_valid=0, o_r_resp=0, o_r_last=0, o_r_data=0, beat counter=0.

Verification
REQ-025 Read addr 0x8000100 len 0 -> o_sel_valid, o_sel_idx=2 one cycle after acceptance; i_sel_ready low 5 cycles -> outputs stable; handshake -> IDLE, o_req_ready=1.
REQ-026 Read addr 0x20000 (bootrom end) len 3 -> no o_sel_valid; 4 R beats resp 2'b11, data 0, o_r_last only on 4th; i_r_ready toggling each cycle -> still exactly 4 beats.
REQ-027 Write addr 0x0 len 1 -> o_w_ready; 2 W beats, i_w_last on 2nd -> o_b_valid resp 2'b11; i_b_ready held low 3 cycles -> o_b_valid held.
REQ-028 Addr 0x100000000 -> o_sel_idx=6; addr 0x10FFFFFFF -> 6; 0x110000000 -> DECERR path; 0xBFFFFFFF -> 5.
REQ-029 Read miss len 7, i_rst=1 after 3 beats -> next cycle all outputs at reset values; new request to 0x2000000 then -> o_sel_idx=1.

Source files
------------

// File: rtl/bus0_slv_decoder.sv
// bus0 slave decoder: routes a single outstanding AR/AW request to one of seven
// slaves by address, and terminates unmapped requests locally with DECERR.
//
// Handshake rule for every channel: a transfer happens on a rising edge where
// valid and ready are both high; a producer holds valid and its payload
// stable until that edge, and ready never waits on valid.
module bus0_slv_decoder #(
    parameter int abits = 48
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [abits-1:0] i_req_addr,
    input  logic             i_req_write,
    input  logic [7:0]       i_req_len,
    output logic             o_sel_valid,
    input  logic             i_sel_ready,
    output logic [2:0]       o_sel_idx,
    output logic [abits-1:0] o_sel_addr,
    output logic             o_sel_write,
    output logic [7:0]       o_sel_len,
    input  logic             i_w_valid,
    input  logic             i_w_last,
    output logic             o_w_ready,
    output logic             o_b_valid,
    output logic [1:0]       o_b_resp,
    input  logic             i_b_ready,
    output logic             o_r_valid,
    output logic [1:0]       o_r_resp,
    output logic             o_r_last,
    output logic [63:0]      o_r_data,
    input  logic             i_r_ready
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ROUTE = 3'd1,
        S_ERR_W = 3'd2,
        S_ERR_B = 3'd3,
        S_ERR_R = 3'd4
    } state_t;

    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Map order is the slave vector order: bootrom, clint, sram, plic, pbridge, ddr, new.
    localparam logic [63:0] MAP_BASE [0:6] = '{
        64'h0000_0000_0001_0000, 64'h0000_0000_0200_0000, 64'h0000_0000_0800_0000,
        64'h0000_0000_0C00_0000, 64'h0000_0000_1000_0000, 64'h0000_0000_8000_0000,
        64'h0000_0001_0000_0000
    };
    localparam logic [63:0] MAP_END [0:6] = '{
        64'h0000_0000_0002_0000, 64'h0000_0000_0201_0000, 64'h0000_0000_0820_0000,
        64'h0000_0000_1000_0000, 64'h0000_0000_1010_0000, 64'h0000_0000_C000_0000,
        64'h0000_0001_1000_0000
    };

    state_t             state_q;
    logic               req_ready_q;
    logic               sel_valid_q;
    logic [2:0]         sel_idx_q;
    logic [abits-1:0]   sel_addr_q;
    logic               sel_write_q;
    logic [7:0]         sel_len_q;
    logic               w_ready_q;
    logic               b_valid_q;
    logic [1:0]         b_resp_q;
    logic               r_valid_q;
    logic [1:0]         r_resp_q;
    logic               r_last_q;
    logic [7:0]         beat_cnt_q;

    logic               hit_d;
    logic [2:0]         hit_idx_d;
    logic [63:0]        base_w;
    logic [63:0]        end_w;

    // Scanning from the top down lets the lowest matching index win.
    always_comb begin
        hit_d     = 1'b0;
        hit_idx_d = 3'd0;
        base_w    = 64'd0;
        end_w     = 64'd0;
        for (int k = 6; k >= 0; k--) begin
            base_w = MAP_BASE[k];
            end_w  = MAP_END[k];
            if ((i_req_addr >= base_w[abits-1:0]) && (i_req_addr < end_w[abits-1:0])) begin
                hit_d     = 1'b1;
                hit_idx_d = 3'(k);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b0;
            sel_valid_q <= 1'b0;
            sel_idx_q   <= 3'd0;
            sel_addr_q  <= '0;
            sel_write_q <= 1'b0;
            sel_len_q   <= 8'd0;
            w_ready_q   <= 1'b0;
            b_valid_q   <= 1'b0;
            b_resp_q    <= 2'b00;
            r_valid_q   <= 1'b0;
            r_resp_q    <= 2'b00;
            r_last_q    <= 1'b0;
            beat_cnt_q  <= 8'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (i_req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        sel_addr_q  <= i_req_addr;
                        sel_write_q <= i_req_write;
                        sel_len_q   <= i_req_len;
                        if (hit_d) begin
                            state_q     <= S_ROUTE;
                            sel_valid_q <= 1'b1;
                            sel_idx_q   <= hit_idx_d;
                        end else if (i_req_write) begin
                            state_q   <= S_ERR_W;
                            w_ready_q <= 1'b1;
                        end else begin
                            state_q    <= S_ERR_R;
                            r_valid_q  <= 1'b1;
                            r_resp_q   <= RESP_DECERR;
                            r_last_q   <= (i_req_len == 8'd0);
                            beat_cnt_q <= i_req_len;
                        end
                    end
                end
                S_ROUTE: begin
                    if (i_sel_ready) begin
                        state_q     <= S_IDLE;
                        sel_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                S_ERR_W: begin
                    // The burst ends on the master's last flag, whatever len claimed.
                    if (i_w_valid && i_w_last) begin
                        state_q   <= S_ERR_B;
                        w_ready_q <= 1'b0;
                        b_valid_q <= 1'b1;
                        b_resp_q  <= RESP_DECERR;
                    end
                end
                S_ERR_B: begin
                    if (i_b_ready) begin
                        state_q     <= S_IDLE;
                        b_valid_q   <= 1'b0;
                        b_resp_q    <= 2'b00;
                        req_ready_q <= 1'b1;
                    end
                end
                S_ERR_R: begin
                    if (i_r_ready) begin
                        if (r_last_q) begin
                            state_q     <= S_IDLE;
                            r_valid_q   <= 1'b0;
                            r_resp_q    <= 2'b00;
                            r_last_q    <= 1'b0;
                            req_ready_q <= 1'b1;
                        end else begin
                            beat_cnt_q <= beat_cnt_q - 8'd1;
                            r_last_q   <= (beat_cnt_q == 8'd1);
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_req_ready = req_ready_q;
    assign o_sel_valid = sel_valid_q;
    assign o_sel_idx   = sel_idx_q;
    assign o_sel_addr  = sel_addr_q;
    assign o_sel_write = sel_write_q;
    assign o_sel_len   = sel_len_q;
    assign o_w_ready   = w_ready_q;
    assign o_b_valid   = b_valid_q;
    assign o_b_resp    = b_resp_q;
    assign o_r_valid   = r_valid_q;
    assign o_r_resp    = r_resp_q;
    assign o_r_last    = r_last_q;
    assign o_r_data    = 64'd0;

endmodule
